// File: rtl/ask_pkg.sv
// ---------------------------------------------------------------------------
// ask_pkg
// Shared types and width helpers for the ASK receive path.
//
// Contents:
//   askState_e  - demodulator state: HUNT (waiting for a carrier burst) or
//                 TRACK (window timing established).
//   phaseWidth  - bits needed to count 0..bitPeriod-1 inside a bit window.
//   edgeWidth   - bits for the per-window carrier edge counter, one wider
//                 than the phase so it can never wrap inside a window.
//   zeroWidth   - bits needed to count 0..idleBits consecutive '0' bits.
// ---------------------------------------------------------------------------
package ask_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } askState_e;

    function automatic int phaseWidth(input int bitPeriod);
        return $clog2(bitPeriod);
    endfunction

    function automatic int edgeWidth(input int bitPeriod);
        return $clog2(bitPeriod) + 1;
    endfunction

    function automatic int zeroWidth(input int idleBits);
        return $clog2(idleBits + 1);
    endfunction

endpackage

// File: rtl/ask_edge_detector.sv
// ---------------------------------------------------------------------------
// ask_edge_detector
// Registers the incoming ASK signal once and flags a rising edge whenever
// the current sample is high and the previous one was low. Kept separate so
// a later carrier-recovery block can reuse the same edge source.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high; clears the delayed sample
//   sig_i   in   ASK input, already synchronous to clk
//   rise_o  out  combinational rising-edge flag for the current cycle
// ---------------------------------------------------------------------------
module ask_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic askDelay_q;

    // Remember last cycle's sample; after reset the line is treated as low,
    // so a high level on the first cycle out of reset counts as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            askDelay_q <= 1'b0;
        end else begin
            askDelay_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~askDelay_q;

endmodule

// File: rtl/ask_demodulator.sv
// ---------------------------------------------------------------------------
// ask_demodulator
// Recovers a bit stream from an on/off-keyed carrier. Carrier rising edges
// are counted over fixed windows of BIT_PERIOD clocks; a window with at
// least EDGE_THRESH edges decodes as '1'. Windows are aligned to the first
// carrier edge seen while hunting and then run back to back with no timing
// correction. IDLE_BITS consecutive '0' decisions end the frame.
//
// Parameters:
//   BIT_PERIOD   clocks per bit window (>= 4)
//   EDGE_THRESH  minimum edges in a window for a '1' (1..BIT_PERIOD/2)
//   IDLE_BITS    consecutive '0' bits that drop lock (>= 1)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   low forces HUNT and discards any partial window
//   ask_in      in   ASK-modulated input, synchronous to clk
//   data_out    out  last decided bit, holds between strobes
//   data_valid  out  one-cycle strobe per decided bit
//   locked      out  high while window timing is established
// ---------------------------------------------------------------------------
module ask_demodulator
    import ask_pkg::*;
#(
    parameter int BIT_PERIOD  = 16,
    parameter int EDGE_THRESH = 3,
    parameter int IDLE_BITS   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic ask_in,
    output logic data_out,
    output logic data_valid,
    output logic locked
);

    localparam int PHASE_W = phaseWidth(BIT_PERIOD);
    localparam int EW      = edgeWidth(BIT_PERIOD);
    localparam int ZW      = zeroWidth(IDLE_BITS);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BIT_PERIOD - 1);
    localparam logic [EW-1:0]      EDGE_MAX   = '1;
    localparam logic [EW-1:0]      THRESH     = EW'(EDGE_THRESH);
    localparam logic [ZW-1:0]      IDLE_LIMIT = ZW'(IDLE_BITS);

    askState_e          state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [EW-1:0]      edgeCnt_q;
    logic [EW-1:0]      edgeCnt_d;
    logic [ZW-1:0]      zeroRun_q;
    logic [ZW-1:0]      zeroRun_d;
    logic               dataOut_q;
    logic               dataValid_q;
    logic               locked_q;
    logic               rise;
    logic               windowEnd;
    logic               bitDecision;

    ask_edge_detector uEdge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (ask_in),
        .rise_o (rise)
    );

    // Edge count including this cycle's edge, so an edge landing in the
    // decision cycle still counts toward the window it belongs to. The count
    // saturates rather than wrapping.
    always_comb begin
        edgeCnt_d = edgeCnt_q;
        if (rise && (edgeCnt_q != EDGE_MAX)) begin
            edgeCnt_d = edgeCnt_q + EW'(1);
        end
    end

    assign windowEnd   = (phase_q == LAST_PHASE);
    assign bitDecision = (edgeCnt_d >= THRESH);
    assign zeroRun_d   = zeroRun_q + ZW'(1);

    // Main receive FSM. HUNT waits for an enabled carrier edge and treats
    // that cycle as phase 0 of the first window, hence phase and edge count
    // both load 1 on the transition. TRACK counts phases and edges, emits a
    // decision strobe one cycle after the last phase, and falls back to HUNT
    // either on enable dropping or on the IDLE_BITS-th '0' in a row. The
    // timeout bit is still strobed out, with locked falling alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            phase_q     <= '0;
            edgeCnt_q   <= '0;
            zeroRun_q   <= '0;
            dataOut_q   <= 1'b0;
            dataValid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            dataValid_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    locked_q  <= 1'b0;
                    phase_q   <= '0;
                    edgeCnt_q <= '0;
                    zeroRun_q <= '0;
                    if (enable && rise) begin
                        state_q   <= TRACK;
                        locked_q  <= 1'b1;
                        phase_q   <= PHASE_W'(1);
                        edgeCnt_q <= EW'(1);
                    end
                end
                TRACK: begin
                    if (!enable) begin
                        state_q   <= HUNT;
                        locked_q  <= 1'b0;
                        phase_q   <= '0;
                        edgeCnt_q <= '0;
                        zeroRun_q <= '0;
                    end else if (windowEnd) begin
                        dataOut_q   <= bitDecision;
                        dataValid_q <= 1'b1;
                        phase_q     <= '0;
                        edgeCnt_q   <= '0;
                        if (bitDecision) begin
                            zeroRun_q <= '0;
                        end else if (zeroRun_d == IDLE_LIMIT) begin
                            state_q   <= HUNT;
                            locked_q  <= 1'b0;
                            zeroRun_q <= '0;
                        end else begin
                            zeroRun_q <= zeroRun_d;
                        end
                    end else begin
                        phase_q   <= phase_q + PHASE_W'(1);
                        edgeCnt_q <= edgeCnt_d;
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_ask_demodulator.sv
// ---------------------------------------------------------------------------
// tb_ask_demodulator
// Self-checking bench for ask_demodulator with BIT_PERIOD=16, EDGE_THRESH=3,
// IDLE_BITS=4. Directed windows are checked as they run; every cycle of the
// whole run is also recorded and compared afterwards against a window-level
// reference model computed from the recorded input trace.
// ---------------------------------------------------------------------------
module tb_ask_demodulator;

    localparam int BP   = 16;
    localparam int TH   = 3;
    localparam int IDLE = 4;
    localparam int MAXC = 4096;

    localparam logic [15:0] CARRIER = 16'h5555;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic ask_in;
    logic data_out;
    logic data_valid;
    logic locked;

    int nChecks = 0;
    int nFails  = 0;
    int cycIdx  = 0;

    bit         trRst  [MAXC];
    bit         trEn   [MAXC];
    bit         trAsk  [MAXC];
    bit         riseArr[MAXC];
    logic [2:0] obs    [MAXC+1];
    bit   [2:0] expv   [MAXC+1];

    typedef struct {
        int rises;
        bit lastCycle;
        bit expBit;
    } winVec_t;

    winVec_t vecs[9];

    ask_demodulator #(
        .BIT_PERIOD  (BP),
        .EDGE_THRESH (TH),
        .IDLE_BITS   (IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ask_in     (ask_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2:0] cur();
        return {data_out, data_valid, locked};
    endfunction

    // Build a window with exactly n rises on odd cycles; with lastCycle set,
    // the final rise is moved to the decision cycle of the window.
    function automatic logic [15:0] makePattern(input int n, input bit lastCycle);
        logic [15:0] p;
        int k;
        p = '0;
        k = lastCycle ? n - 1 : n;
        for (int i = 0; i < k; i++) begin
            p[2*i+1] = 1'b1;
        end
        if (lastCycle && n > 0) begin
            p[BP-1] = 1'b1;
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [2:0] act,
                               input logic [2:0] exp, input logic [2:0] mask);
        nChecks++;
        if ((act & mask) !== (exp & mask)) begin
            nFails++;
            $display("[TB] FAIL %s: got {out,valid,locked}=%b, required %b (mask %b)",
                     name, act, exp, mask);
        end
    endtask

    // Drive one cycle of inputs, record them, and sample outputs 2 units
    // after the rising edge that ends the cycle.
    task automatic applyStimulus(input bit r, input bit e, input bit a);
        reset  = r;
        enable = e;
        ask_in = a;
        if (cycIdx < MAXC) begin
            trRst[cycIdx] = r;
            trEn[cycIdx]  = e;
            trAsk[cycIdx] = a;
        end
        @(posedge clk);
        #2;
        if (cycIdx < MAXC) begin
            obs[cycIdx+1] = cur();
        end
        cycIdx++;
    endtask

    // One full enabled window: no strobe and locked high mid-window, then a
    // strobe with the expected bit and lock state right after the last cycle.
    task automatic sendWindow(input logic [15:0] pat, input bit expBit,
                              input bit expLock, input string tag);
        for (int j = 0; j < BP; j++) begin
            applyStimulus(1'b0, 1'b1, pat[j]);
            if (j < BP - 1) begin
                checkOutput($sformatf("%s mid %0d", tag, j), cur(), 3'b001, 3'b011);
            end else begin
                checkOutput($sformatf("%s strobe", tag), cur(), {expBit, 1'b1, expLock}, 3'b111);
            end
        end
    endtask

    task automatic setExp(input int n, input int idx, input bit [2:0] v);
        if (idx <= n) begin
            expv[idx] = v;
        end
    endtask

    // Reference model at window granularity: scan for an enabled edge, then
    // walk whole windows, counting edges in each, until enable drops, reset
    // hits, or IDLE zero bits in a row end the frame.
    task automatic buildModel(input int n);
        bit prevAsk;
        bit lastOut;
        bit hunting;
        bit bitVal;
        int k;
        int start;
        int zeros;
        int rises;
        int j;
        int cyc;
        prevAsk = 1'b0;
        lastOut = 1'b0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            riseArr[i] = trAsk[i] & ~prevAsk;
            prevAsk = trRst[i] ? 1'b0 : trAsk[i];
        end
        for (int i = 0; i <= n; i++) begin
            expv[i] = 3'b000;
        end
        while (k < n) begin
            if (trRst[k]) begin
                lastOut = 1'b0;
                setExp(n, k + 1, 3'b000);
                k++;
            end else if (!(trEn[k] && riseArr[k])) begin
                setExp(n, k + 1, {lastOut, 2'b00});
                k++;
            end else begin
                start = k;
                zeros = 0;
                hunting = 1'b0;
                while (!hunting) begin
                    rises = 0;
                    for (j = 0; j < BP; j++) begin
                        cyc = start + j;
                        if (cyc >= n) break;
                        if (trRst[cyc]) begin
                            lastOut = 1'b0;
                            setExp(n, cyc + 1, 3'b000);
                            break;
                        end
                        if (!trEn[cyc]) begin
                            setExp(n, cyc + 1, {lastOut, 2'b00});
                            break;
                        end
                        rises += int'(riseArr[cyc]);
                        if (j < BP - 1) begin
                            setExp(n, cyc + 1, {lastOut, 2'b01});
                        end
                    end
                    if (j < BP) begin
                        hunting = 1'b1;
                        k = start + j + 1;
                    end else begin
                        bitVal = (rises >= TH);
                        lastOut = bitVal;
                        zeros = bitVal ? 0 : zeros + 1;
                        if (zeros == IDLE) begin
                            setExp(n, start + BP, {bitVal, 2'b10});
                            hunting = 1'b1;
                            k = start + BP;
                        end else begin
                            setExp(n, start + BP, {bitVal, 2'b11});
                            start = start + BP;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int n;
        int holdLeft;
        int mode;
        bit r;
        bit e;
        bit a;

        vecs[0] = '{2, 1'b0, 1'b0};
        vecs[1] = '{3, 1'b1, 1'b1};
        vecs[2] = '{8, 1'b0, 1'b1};
        vecs[3] = '{0, 1'b0, 1'b0};
        vecs[4] = '{1, 1'b0, 1'b0};
        vecs[5] = '{4, 1'b0, 1'b1};
        vecs[6] = '{3, 1'b0, 1'b1};
        vecs[7] = '{2, 1'b1, 1'b0};
        vecs[8] = '{5, 1'b0, 1'b1};

        reset  = 1'b1;
        enable = 1'b0;
        ask_in = 1'b0;

        $display("[TB] reset with toggling input");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 2) == 0);
            checkOutput($sformatf("reset hold %0d", i), cur(), 3'b000, 3'b111);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("after reset release", cur(), 3'b000, 3'b111);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] bits 1,0,1,1 from first carrier edge");
        sendWindow(CARRIER, 1'b1, 1'b1, "bits w0");
        sendWindow(16'h0000, 1'b0, 1'b1, "bits w1");
        sendWindow(CARRIER, 1'b1, 1'b1, "bits w2");
        sendWindow(CARRIER, 1'b1, 1'b1, "bits w3");

        $display("[TB] threshold table");
        for (int v = 0; v < 9; v++) begin
            sendWindow(makePattern(vecs[v].rises, vecs[v].lastCycle), vecs[v].expBit, 1'b1,
                       $sformatf("thresh %0d", v));
        end

        $display("[TB] idle timeout and re-acquisition");
        sendWindow(CARRIER, 1'b1, 1'b1, "idle lead");
        for (int z = 0; z < IDLE; z++) begin
            sendWindow(16'h0000, 1'b0, (z != IDLE - 1), $sformatf("idle zero %0d", z));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("hunting after timeout", cur(), 3'b000, 3'b011);
        sendWindow(CARRIER, 1'b1, 1'b1, "relock");

        $display("[TB] enable dropped mid-window");
        for (int j = 0; j < 7; j++) begin
            applyStimulus(1'b0, 1'b1, CARRIER[j]);
            checkOutput($sformatf("pre-drop %0d", j), cur(), 3'b001, 3'b011);
        end
        applyStimulus(1'b0, 1'b0, CARRIER[7]);
        checkOutput("enable drop", cur(), 3'b000, 3'b011);
        for (int j = 0; j < 24; j++) begin
            applyStimulus(1'b0, 1'b0, (j % 2) == 0);
            checkOutput($sformatf("disabled %0d", j), cur(), 3'b000, 3'b011);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("re-enable idle", cur(), 3'b000, 3'b011);
        sendWindow(CARRIER, 1'b1, 1'b1, "re-enable");

        $display("[TB] reset during tracking");
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b0, 1'b1, CARRIER[j]);
            checkOutput($sformatf("pre-reset %0d", j), cur(), 3'b001, 3'b011);
        end
        applyStimulus(1'b1, 1'b1, CARRIER[10]);
        checkOutput("reset abort", cur(), 3'b000, 3'b111);
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("after abort %0d", j), cur(), 3'b000, 3'b111);
        end

        $display("[TB] randomized traffic");
        holdLeft = 0;
        mode = 0;
        for (int c = 0; c < 2400; c++) begin
            if (holdLeft == 0) begin
                mode = int'($urandom_range(0, 4));
                holdLeft = int'($urandom_range(6, 40));
            end
            holdLeft--;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 149) != 0);
            case (mode)
                0:       a = 1'b0;
                3:       a = 1'($urandom_range(0, 1));
                default: a = ((c % 2) == 0);
            endcase
            applyStimulus(r, e, a);
        end

        n = (cycIdx < MAXC) ? cycIdx : MAXC;
        buildModel(n);
        for (int i = 1; i <= n; i++) begin
            checkOutput($sformatf("model cycle %0d", i), obs[i], expv[i], 3'b111);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
